// File: rtl/card_mem_pkg.sv
// Shared encodings for the card memory sequencer: FSM states, card entry fields
// and the Fisher-Yates index picker.
package card_mem_pkg;

  localparam int unsigned N_CARDS      = 16;
  localparam int unsigned IDX_W        = $clog2(N_CARDS);
  localparam int unsigned BIT_REMOVED  = 5;
  localparam int unsigned BIT_FACEDOWN = 4;
  localparam int unsigned VAL_MSB      = 3;
  localparam int unsigned VAL_W        = VAL_MSB + 1;

  localparam logic [5:0] EMPTY_CARD   = 6'b100000;
  localparam logic [1:0] FACEDOWN_TAG = 2'b01;

  typedef enum logic [3:0] {
    SERVE   = 4'd0,
    FILL    = 4'd1,
    SH_PICK = 4'd2,
    SH_RD_I = 4'd3,
    SH_RD_J = 4'd4,
    SH_CAP  = 4'd5,
    SH_WR_I = 4'd6,
    SH_WR_J = 4'd7,
    DONE    = 4'd8
  } seq_state_t;

  // Fold an out-of-range random value back into 0..i so the swap partner never exceeds i.
  function automatic logic [IDX_W-1:0] pick_index(input logic [IDX_W-1:0] r,
                                                  input logic [IDX_W-1:0] i);
    return (r <= i) ? r : (r & i);
  endfunction

endpackage

// File: rtl/card_fill_shuffle_fsm.sv
// Board initialisation sequencer: fills value pairs face-down, optionally shuffles
// them, and drives port B whenever it is not in SERVE.
module card_fill_shuffle_fsm #(
  parameter int unsigned N_CARDS    = 16,
  parameter int unsigned DATA_W     = 6,
  parameter int unsigned SHUFFLE_EN = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init_start,
  input  logic                       gm_wr_req,
  input  logic [7:0]                 rand_bits,
  input  logic [DATA_W-1:0]          mem_dout,
  output logic                       busy,
  output logic                       init_done,
  output logic                       serve_c,
  output logic [$clog2(N_CARDS)-1:0] seq_addr_c,
  output logic                       seq_we_c,
  output logic [DATA_W-1:0]          seq_din_c
);
  import card_mem_pkg::*;

  localparam int unsigned ADDR_W = $clog2(N_CARDS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_CARDS - 1);

  seq_state_t          state;
  seq_state_t          state_nx;
  logic [ADDR_W-1:0]   k;
  logic [ADDR_W-1:0]   i;
  logic [ADDR_W-1:0]   j;
  logic [DATA_W-1:0]   di;
  logic [DATA_W-1:0]   dj;
  logic                unused_rand;

  assign unused_rand = ^rand_bits[7:ADDR_W];
  assign serve_c     = (state == SERVE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SERVE;
    else        state <= state_nx;
  end

  // Next state and port B drive while initialising.
  always_comb begin
    state_nx   = state;
    seq_addr_c = '0;
    seq_we_c   = 1'b0;
    seq_din_c  = dj;
    case (state)
      SERVE: begin
        if (init_start && !gm_wr_req) state_nx = FILL;
      end
      FILL: begin
        seq_addr_c = k;
        seq_we_c   = 1'b1;
        seq_din_c  = DATA_W'({FACEDOWN_TAG, VAL_W'(k >> 1)});
        if (k == LAST_IDX) state_nx = (SHUFFLE_EN != 0) ? SH_PICK : DONE;
      end
      SH_PICK: begin
        seq_addr_c = i;
        state_nx   = SH_RD_I;
      end
      SH_RD_I: begin
        seq_addr_c = i;
        state_nx   = SH_RD_J;
      end
      SH_RD_J: begin
        seq_addr_c = j;
        state_nx   = SH_CAP;
      end
      SH_CAP: begin
        seq_addr_c = j;
        state_nx   = SH_WR_I;
      end
      SH_WR_I: begin
        seq_addr_c = i;
        seq_we_c   = 1'b1;
        seq_din_c  = dj;
        state_nx   = SH_WR_J;
      end
      SH_WR_J: begin
        seq_addr_c = j;
        seq_we_c   = 1'b1;
        seq_din_c  = di;
        state_nx   = (i == ADDR_W'(1)) ? DONE : SH_PICK;
      end
      DONE:    state_nx = SERVE;
      default: state_nx = SERVE;
    endcase
  end

  // Fill counter, shuffle indices and swap data, plus registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k         <= '0;
      i         <= LAST_IDX;
      j         <= '0;
      di        <= '0;
      dj        <= '0;
      busy      <= 1'b0;
      init_done <= 1'b0;
    end else begin
      busy      <= (state_nx != SERVE) && (state_nx != DONE);
      init_done <= (state_nx == DONE);
      case (state)
        SERVE: k <= '0;
        FILL: begin
          k <= k + ADDR_W'(1);
          i <= LAST_IDX;
        end
        SH_PICK: j  <= pick_index(rand_bits[ADDR_W-1:0], i);
        SH_RD_J: di <= mem_dout;
        SH_CAP:  dj <= mem_dout;
        SH_WR_J: begin
          if (i != ADDR_W'(1)) i <= i - ADDR_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/card_mem_sequencer.sv
// Port B owner of the card memory: board initialisation, gameplay write
// arbitration and the cursor read pipeline.
module card_mem_sequencer #(
  parameter int unsigned N_CARDS    = 16,
  parameter int unsigned DATA_W     = 6,
  parameter int unsigned SHUFFLE_EN = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init_start,
  input  logic [7:0]                 rand_bits,
  output logic                       busy,
  output logic                       init_done,
  input  logic                       gm_wr_req,
  input  logic [$clog2(N_CARDS)-1:0] gm_wr_loc,
  input  logic [DATA_W-1:0]          gm_wr_data,
  output logic                       gm_wr_ack,
  input  logic [$clog2(N_CARDS)-1:0] cur_loc,
  output logic [DATA_W-1:0]          cur_data,
  output logic                       cur_valid,
  output logic [$clog2(N_CARDS)-1:0] mem_addr,
  output logic                       mem_we,
  output logic [DATA_W-1:0]          mem_din,
  input  logic [DATA_W-1:0]          mem_dout
);
  import card_mem_pkg::*;

  localparam int unsigned ADDR_W = $clog2(N_CARDS);

  logic                serve_c;
  logic [ADDR_W-1:0]   seq_addr_c;
  logic                seq_we_c;
  logic [DATA_W-1:0]   seq_din_c;
  logic                cur_rd_c;
  logic                rd_q;

  card_fill_shuffle_fsm #(
    .N_CARDS    (N_CARDS),
    .DATA_W     (DATA_W),
    .SHUFFLE_EN (SHUFFLE_EN)
  ) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .init_start (init_start),
    .gm_wr_req  (gm_wr_req),
    .rand_bits  (rand_bits),
    .mem_dout   (mem_dout),
    .busy       (busy),
    .init_done  (init_done),
    .serve_c    (serve_c),
    .seq_addr_c (seq_addr_c),
    .seq_we_c   (seq_we_c),
    .seq_din_c  (seq_din_c)
  );

  // In SERVE a pending gameplay write wins the slot; otherwise the cursor reads.
  always_comb begin
    mem_addr  = seq_addr_c;
    mem_we    = seq_we_c;
    mem_din   = seq_din_c;
    gm_wr_ack = 1'b0;
    if (serve_c) begin
      mem_addr  = gm_wr_req ? gm_wr_loc : cur_loc;
      mem_we    = gm_wr_req;
      mem_din   = gm_wr_data;
      gm_wr_ack = gm_wr_req;
    end
  end

  assign cur_rd_c = serve_c && !gm_wr_req;

  // Read data is only trusted if no write or init cycle followed the cursor read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q      <= 1'b0;
      cur_valid <= 1'b0;
      cur_data  <= DATA_W'(EMPTY_CARD);
    end else begin
      rd_q      <= cur_rd_c;
      cur_valid <= rd_q && cur_rd_c;
      if (rd_q && cur_rd_c) cur_data <= mem_dout;
    end
  end

endmodule
